ps2_keyboard_fifo: RTL and testbench
====================================

PS2_KEYBOARD_FIFO -- requirements
Module: ps2_keyboard_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning scancode FIFO entries; legal values are powers of two, 2..64.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000, meaning the clk cycles without a ps2_clk falling edge that abort a partial frame.
REQ-003 SHALL have port clk, input, 1 bit: system clock; all state updates on the rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 SHALL have port ps2_clk, input, 1 bit: asynchronous PS/2 clock line.
REQ-006 SHALL have port ps2_data, input, 1 bit: asynchronous PS/2 data line.
REQ-007 SHALL have port DataAdr, input, 32 bits: CPU byte address; only bits [3:2] are decoded.
REQ-008 SHALL have port WriteData, input, 32 bits: CPU store data.
REQ-009 SHALL have port enable, input, 1 bit: block select from the address decoder.
REQ-010 SHALL have port MemWrite, input, 1 bit: store strobe; enable with MemWrite=0 is a read.
REQ-011 SHALL have port ReadData, output, 32 bits: combinational read data for the addressed register.
REQ-012 SHALL have port code, output, 8 bits: last valid scancode received.
REQ-013 SHALL have port irq, output, 1 bit: registered interrupt request.

Function
REQ-014 SHALL synchronise ps2_clk and ps2_data through two flops each, and detect a ps2_clk falling edge from the synchronised value and one extra history flop.
REQ-015 SHALL run a receive FSM: IDLE -> DATA (8 bits, LSB first) -> PARITY -> STOP -> IDLE, advancing once per falling edge.
REQ-016 SHALL, in IDLE, leave IDLE only on a falling edge with data=0 (start bit); data=1 on an edge keeps the FSM in IDLE.
REQ-017 SHALL accept a frame only with odd parity over data+parity and stop bit=1; otherwise it SHALL set sticky frame_err and discard the byte.
REQ-018 SHALL, outside IDLE, return to IDLE and set frame_err when TIMEOUT_CYCLES cycles pass without a falling edge.
REQ-019 SHALL push an accepted byte into the FIFO in the cycle after the STOP edge and update code in the same cycle.
REQ-020 SHALL define register offset 0x0 DATA: read returns {23'b0, valid, byte} and, when not empty, pops the head on that clock edge; a read while empty returns 0 and pops nothing.
REQ-021 SHALL define offset 0x4 STATUS (read-only): bit0 empty, bit1 full, bit2 overflow, bit3 frame_err, bits[14:8] count.
REQ-022 SHALL define offset 0x8 CONTROL: bit0 flush (self-clearing), bit1 clear overflow and frame_err (self-clearing), bit2 irq_en (held); reads return {29'b0, irq_en, 2'b00}.
REQ-023 SHALL return 0 for offset 0xC and for any read with enable=0; writes to DATA and STATUS SHALL be ignored.
REQ-024 SHALL, on a push while full with no same-cycle pop, drop the byte and set sticky overflow.
REQ-025 SHALL, on a push and a pop in the same cycle, perform both; a push into a full FIFO is accepted when a pop occurs in that cycle.
REQ-026 SHALL give flush priority over a same-cycle push or pop: count becomes 0 and both bytes are lost.
REQ-027 SHALL give a push priority over a same-cycle error clear: if the push overflows, overflow ends set.
REQ-028 SHALL keep count in $clog2(DEPTH)+1 bits and wrap read and write pointers modulo DEPTH.
REQ-029 SHALL drive irq registered as irq_en AND (not empty OR overflow OR frame_err).

Reset
REQ-030 SHALL, on reset, set FSM=IDLE, FIFO pointers and count=0, overflow=0, frame_err=0, irq_en=0, code=8'h00, irq=0, and synchroniser flops=1 (idle line).
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame and push nothing.

Structure
REQ-032 SHALL place the FSM state enum, register offsets (0x0/0x4/0x8) and STATUS/CONTROL bit positions in shared package ps2_pkg.
REQ-033 SHALL implement the synchroniser, receive FSM and timeout in sub-module ps2_rx, which outputs byte, byte_valid and frame_err pulses; the FIFO and register file SHALL be in the top module.

Verification
REQ-034 SHALL cover: send frame 0x1C with parity 0 and stop 1 -> STATUS count=1, code=8'h1C, DATA read=0x11C, then STATUS=0x001 (empty).
REQ-035 SHALL cover: send 0x1C with parity 1 -> frame_err=1, count=0, code unchanged.
REQ-036 SHALL cover: with DEPTH=8, send 9 valid bytes without reads -> count=8, full=1, overflow=1, first 8 bytes read back in order.
REQ-037 SHALL cover: ps2_clk stopped after 4 data bits for TIMEOUT_CYCLES+1 cycles -> FSM IDLE, frame_err=1, then the next full frame is received correctly.
REQ-038 SHALL cover: FIFO full, and a DATA read coinciding with a push -> count stays 8, overflow stays 0.
REQ-039 SHALL cover: write CONTROL=0x4, then push one byte -> irq=1 one cycle after the push; write CONTROL=0x5 -> count=0, irq=0 on the next cycle.

Source files
------------

// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Shared definitions for the PS/2 keyboard receiver and its
//               memory-mapped scancode FIFO: receive FSM state encoding,
//               register word offsets and STATUS/CONTROL bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    // Receive FSM states, one step per PS/2 clock falling edge.
    typedef enum logic [1:0] {
        RX_IDLE   = 2'd0,
        RX_DATA   = 2'd1,
        RX_PARITY = 2'd2,
        RX_STOP   = 2'd3
    } rx_state_t;

    // Register word index, taken from CPU address bits [3:2].
    localparam logic [1:0] c_off_data    = 2'd0;  // byte offset 0x0
    localparam logic [1:0] c_off_status  = 2'd1;  // byte offset 0x4
    localparam logic [1:0] c_off_control = 2'd2;  // byte offset 0x8

    // STATUS bit positions.
    localparam int c_stat_empty   = 0;
    localparam int c_stat_full    = 1;
    localparam int c_stat_ovf     = 2;
    localparam int c_stat_ferr    = 3;
    localparam int c_stat_cnt_lsb = 8;
    localparam int c_stat_cnt_w   = 7;

    // CONTROL bit positions.
    localparam int c_ctrl_flush  = 0;
    localparam int c_ctrl_clear  = 1;
    localparam int c_ctrl_irq_en = 2;

    // PS/2 uses odd parity over the eight data bits plus the parity bit.
    function automatic logic parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 device-to-host frame receiver. Synchronises the PS/2
//               clock and data lines, detects clock falling edges, and walks
//               start / 8 data (LSB first) / parity / stop. Aborts a partial
//               frame after TIMEOUT_CYCLES clocks without a falling edge.
// Ports       : clk, reset        - system clock, sync active-high reset
//               ps2_clk, ps2_data - asynchronous PS/2 lines
//               rx_byte           - last accepted byte
//               byte_valid        - one-cycle pulse, rx_byte is new
//               frame_err         - one-cycle pulse, bad parity/stop/timeout
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int c_tw = $clog2(TIMEOUT_CYCLES + 1);

    // Synchronisers; reset to 1 so an idle line produces no false edge.
    logic r_clk_s1, r_clk_s2, r_clk_hist;
    logic r_dat_s1, r_dat_s2;
    logic w_fall;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1   <= 1'b1;
            r_clk_s2   <= 1'b1;
            r_clk_hist <= 1'b1;
            r_dat_s1   <= 1'b1;
            r_dat_s2   <= 1'b1;
        end else begin
            r_clk_s1   <= ps2_clk;
            r_clk_s2   <= r_clk_s1;
            r_clk_hist <= r_clk_s2;
            r_dat_s1   <= ps2_data;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_hist & ~r_clk_s2;

    rx_state_t         r_state, w_state_next;
    logic [2:0]        r_bit_cnt;
    logic [7:0]        r_shift;
    logic              r_parity;
    logic [c_tw-1:0]   r_tmo_cnt;
    logic              w_timeout;
    logic              w_stop_edge;
    logic              w_frame_good;
    logic              w_frame_bad;
    logic [7:0]        r_byte;
    logic              r_byte_valid;
    logic              r_frame_err;

    // The counter holds the number of cycles already spent without an edge,
    // so the abort fires on the TIMEOUT_CYCLES-th quiet cycle.
    assign w_timeout = (r_state != RX_IDLE) && !w_fall &&
                       (r_tmo_cnt == c_tw'(TIMEOUT_CYCLES - 1));

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = RX_IDLE;
        end else if (w_fall) begin
            case (r_state)
                RX_IDLE:   if (!r_dat_s2) w_state_next = RX_DATA;
                RX_DATA:   if (r_bit_cnt == 3'd7) w_state_next = RX_PARITY;
                RX_PARITY: w_state_next = RX_STOP;
                RX_STOP:   w_state_next = RX_IDLE;
                default:   w_state_next = RX_IDLE;
            endcase
        end
    end

    // Output decode: frame verdict on the stop-bit edge, or on timeout.
    always_comb begin
        w_stop_edge  = (r_state == RX_STOP) && w_fall;
        w_frame_good = w_stop_edge && r_dat_s2 && parity_ok(r_shift, r_parity);
        w_frame_bad  = (w_stop_edge && !(r_dat_s2 && parity_ok(r_shift, r_parity))) ||
                       w_timeout;
    end

    // Datapath: shift register, bit counter, timeout counter, output pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt    <= 3'd0;
            r_shift      <= 8'h00;
            r_parity     <= 1'b0;
            r_tmo_cnt    <= '0;
            r_byte       <= 8'h00;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (w_fall) begin
                case (r_state)
                    RX_IDLE: r_bit_cnt <= 3'd0;
                    RX_DATA: begin
                        r_shift   <= {r_dat_s2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                    end
                    RX_PARITY: r_parity <= r_dat_s2;
                    default: ;
                endcase
            end

            if ((r_state == RX_IDLE) || w_fall || w_timeout) begin
                r_tmo_cnt <= '0;
            end else begin
                r_tmo_cnt <= r_tmo_cnt + 1'b1;
            end

            r_byte_valid <= w_frame_good;
            r_frame_err  <= w_frame_bad;
            if (w_frame_good) begin
                r_byte <= r_shift;
            end
        end
    end

    assign rx_byte    = r_byte;
    assign byte_valid = r_byte_valid;
    assign frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ps2_keyboard_fifo
// Description : Memory-mapped PS/2 keyboard port. Received scancodes are
//               queued in a DEPTH-entry FIFO read through a small register
//               file (DATA / STATUS / CONTROL), with a level interrupt.
// Ports       : clk, reset            - system clock, sync active-high reset
//               ps2_clk, ps2_data     - asynchronous PS/2 lines
//               DataAdr, WriteData    - CPU address / store data
//               enable, MemWrite      - block select and store strobe
//               ReadData              - combinational read data
//               code                  - last valid scancode
//               irq                   - registered interrupt request
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_keyboard_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH          = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        enable,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic [7:0]  code,
    output logic        irq
);

    localparam int c_aw = $clog2(DEPTH);

    // ------------------------------------------------------------------
    // Receiver
    // ------------------------------------------------------------------
    logic [7:0] w_rx_byte;
    logic       w_rx_valid;
    logic       w_rx_ferr;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .reset      (reset),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .rx_byte    (w_rx_byte),
        .byte_valid (w_rx_valid),
        .frame_err  (w_rx_ferr)
    );

    // ------------------------------------------------------------------
    // Bus decode
    // ------------------------------------------------------------------
    logic [1:0] w_off;
    logic       w_rd, w_wr, w_ctrl_wr;
    logic       w_flush, w_clear;
    logic       w_unused_bits;

    assign w_off     = DataAdr[3:2];
    assign w_rd      = enable && !MemWrite;
    assign w_wr      = enable && MemWrite;
    assign w_ctrl_wr = w_wr && (w_off == c_off_control);
    assign w_flush   = w_ctrl_wr && WriteData[c_ctrl_flush];
    assign w_clear   = w_ctrl_wr && WriteData[c_ctrl_clear];

    assign w_unused_bits = &{1'b0, DataAdr[31:4], DataAdr[1:0], WriteData[31:3]};

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    r_mem [DEPTH];
    logic [c_aw-1:0] r_wr_ptr, r_rd_ptr;
    logic [c_aw:0]   r_count;
    logic            w_empty, w_full;
    logic            w_pop, w_push, w_ovf_set;
    logic            r_overflow, r_frame_err, r_irq_en, r_irq;
    logic [7:0]      r_code;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (c_aw+1)'(DEPTH));

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // still accepted when it coincides with a DATA read. Flush wins over both.
    assign w_pop     = w_rd && (w_off == c_off_data) && !w_empty && !w_flush;
    assign w_push    = w_rx_valid && (!w_full || w_pop) && !w_flush;
    assign w_ovf_set = w_rx_valid && w_full && !w_pop && !w_flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_rx_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Sticky flags: a new event in the same cycle beats a clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_frame_err <= 1'b0;
            r_irq_en    <= 1'b0;
            r_code      <= 8'h00;
            r_irq       <= 1'b0;
        end else begin
            if (w_ovf_set)    r_overflow <= 1'b1;
            else if (w_clear) r_overflow <= 1'b0;

            if (w_rx_ferr)    r_frame_err <= 1'b1;
            else if (w_clear) r_frame_err <= 1'b0;

            if (w_ctrl_wr) r_irq_en <= WriteData[c_ctrl_irq_en];

            if (w_rx_valid) r_code <= w_rx_byte;

            r_irq <= r_irq_en && (!w_empty || r_overflow || r_frame_err);
        end
    end

    // ------------------------------------------------------------------
    // Read mux
    // ------------------------------------------------------------------
    logic [31:0] w_status;
    logic [31:0] w_read_data;

    always_comb begin
        w_status                                    = '0;
        w_status[c_stat_empty]                      = w_empty;
        w_status[c_stat_full]                       = w_full;
        w_status[c_stat_ovf]                        = r_overflow;
        w_status[c_stat_ferr]                       = r_frame_err;
        w_status[c_stat_cnt_lsb +: c_stat_cnt_w]    = c_stat_cnt_w'(r_count);
    end

    always_comb begin
        w_read_data = '0;
        if (w_rd) begin
            case (w_off)
                c_off_data:    if (!w_empty) w_read_data = {23'b0, 1'b1, r_mem[r_rd_ptr]};
                c_off_status:  w_read_data = w_status;
                c_off_control: w_read_data[c_ctrl_irq_en] = r_irq_en;
                default:       w_read_data = '0;
            endcase
        end
    end

    assign ReadData = w_read_data;
    assign code     = r_code;
    assign irq      = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyboard_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_keyboard_fifo
// Description : Self-checking bench for ps2_keyboard_fifo. A PS/2 device is
//               emulated bit by bit; a queue-based model of the scancode FIFO
//               and its sticky flags supplies every expected value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_keyboard_fifo;

    localparam int DEPTH = 8;
    localparam int TMO   = 100;
    localparam int HALF  = 20;   // clk cycles per PS/2 clock half-period

    logic        clk = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic        enable;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [7:0]  code;
    logic        irq;

    ps2_keyboard_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .DataAdr   (DataAdr),
        .WriteData (WriteData),
        .enable    (enable),
        .MemWrite  (MemWrite),
        .ReadData  (ReadData),
        .code      (code),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model
    logic [7:0] q[$];
    bit         m_ovf, m_ferr, m_irq_en;
    logic [7:0] m_code;

    function automatic logic [31:0] exp_status();
        int cnt;
        cnt = q.size();
        return {17'b0, 7'(cnt), 4'b0, m_ferr, m_ovf, (cnt == DEPTH), (cnt == 0)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cpu_read(input logic [31:0] addr, output logic [31:0] d);
        @(negedge clk);
        DataAdr = addr; MemWrite = 1'b0; enable = 1'b1;
        #1 d = ReadData;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] addr, input logic [31:0] wd);
        @(negedge clk);
        DataAdr = addr; WriteData = wd; MemWrite = 1'b1; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0; MemWrite = 1'b0;
    endtask

    task automatic ctrl_write(input logic [2:0] wd);
        cpu_write(32'h8, {29'b0, wd});
        if (wd[0]) q.delete();
        if (wd[1]) begin m_ovf = 1'b0; m_ferr = 1'b0; end
        m_irq_en = wd[2];
    endtask

    task automatic read_data_model(input string tag);
        logic [31:0] d, e;
        cpu_read(32'h0, d);
        if (q.size() == 0) e = 32'h0;
        else e = {23'b0, 1'b1, q.pop_front()};
        check(tag, d, e);
    endtask

    task automatic check_status(input string tag);
        logic [31:0] d;
        cpu_read(32'h4, d);
        check(tag, d, exp_status());
    endtask

    task automatic check_irq(input string tag);
        @(posedge clk); #1;
        check(tag, {31'b0, irq}, {31'b0, m_irq_en && (q.size() != 0 || m_ovf || m_ferr)});
    endtask

    // hook: 0 none, 1 DATA read aligned with the push, 2 irq timing probe.
    // The push lands on the 4th rising edge after the stop-bit falling edge
    // (two synchroniser flops, history flop, registered byte_valid).
    task automatic send_bits(input logic [10:0] bits, input int n, input int hook);
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            if (hook == 1 && i == n - 1) begin
                repeat (3) @(posedge clk);
                @(negedge clk);
                DataAdr = 32'h0; MemWrite = 1'b0; enable = 1'b1;
                #1 d = ReadData;
                check("coinc_read", d, {23'b0, 1'b1, q[0]});
                void'(q.pop_front());
                @(negedge clk);
                enable = 1'b0;
                repeat (HALF - 5) @(negedge clk);
            end else if (hook == 2 && i == n - 1) begin
                repeat (4) @(posedge clk);
                #1 check("irq_at_push", {31'b0, irq}, 32'h0);
                @(posedge clk);
                #1 check("irq_after_push", {31'b0, irq}, 32'h1);
                repeat (HALF - 6) @(negedge clk);
            end else begin
                repeat (HALF) @(negedge clk);
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit perr, input bit serr, input int hook);
        logic [10:0] bits;
        bits = {~serr, ~(^b) ^ perr, b, 1'b0};
        send_bits(bits, 11, hook);
        if (!perr && !serr) begin
            m_code = b;
            if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1'b1;
        end else begin
            m_ferr = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        q.delete();
        m_ovf = 1'b0; m_ferr = 1'b0; m_irq_en = 1'b0; m_code = 8'h00;
    endtask

    initial begin
        #3ms;
        $error("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        int          r;

        ps2_clk = 1'b1; ps2_data = 1'b1;
        DataAdr = '0; WriteData = '0; enable = 1'b0; MemWrite = 1'b0;
        do_reset();

        // Reset state
        check_status("reset_status");
        check("reset_status_const", exp_status(), 32'h001);
        check("reset_code", {24'b0, code}, 32'h0);
        check("reset_irq", {31'b0, irq}, 32'h0);
        cpu_read(32'h8, d); check("reset_control", d, 32'h0);
        read_data_model("empty_read");
        cpu_read(32'hC, d); check("offset_c", d, 32'h0);

        // Valid frame 0x1C
        send_frame(8'h1C, 1'b0, 1'b0, 0);
        cpu_read(32'h4, d); check("one_byte_status", d, 32'h100);
        check("one_byte_code", {24'b0, code}, 32'h1C);
        @(negedge clk); DataAdr = 32'h0; enable = 1'b0;
        #1 check("read_disabled", ReadData, 32'h0);
        cpu_write(32'h0, 32'hFF); cpu_write(32'h4, 32'hFF);
        cpu_read(32'h4, d); check("write_ignored", d, 32'h100);
        cpu_read(32'h0, d); check("data_0x11c", d, 32'h11C);
        void'(q.pop_front());
        cpu_read(32'h4, d); check("empty_after_pop", d, 32'h001);

        // Parity error
        send_frame(8'h1C, 1'b1, 1'b0, 0);
        cpu_read(32'h4, d); check("parity_err_status", d, 32'h009);
        check("parity_err_code", {24'b0, code}, 32'h1C);
        ctrl_write(3'b010);
        check_status("clear_flags");

        // Overflow
        for (int i = 0; i < DEPTH + 1; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
        cpu_read(32'h4, d); check("overflow_status", d, 32'h806);
        for (int i = 0; i < DEPTH; i++) read_data_model("overflow_drain");
        cpu_read(32'h4, d); check("drained_status", d, 32'h005);
        ctrl_write(3'b010);

        // Timeout after 4 data bits
        send_bits(11'b0000_1010_110, 5, 0);
        repeat (TMO + 1) @(negedge clk);
        m_ferr = 1'b1;
        cpu_read(32'h4, d); check("timeout_status", d, 32'h009);
        ctrl_write(3'b010);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b0, 1'b0, 0);
        check_status("post_timeout_status");
        check("post_timeout_code", {24'b0, code}, {24'b0, b});
        read_data_model("post_timeout_data");

        // Full FIFO, DATA read coinciding with push
        for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 0);
        cpu_read(32'h4, d); check("full_status", d, 32'h802);
        send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1);
        cpu_read(32'h4, d); check("coinc_status", d, 32'h802);
        for (int i = 0; i < DEPTH; i++) read_data_model("coinc_drain");

        // Interrupt enable / flush
        ctrl_write(3'b100);
        check_irq("irq_idle");
        send_frame(8'h5A, 1'b0, 1'b0, 2);
        cpu_read(32'h8, d); check("control_read", d, 32'h4);
        ctrl_write(3'b101);
        @(posedge clk);
        #1 check("irq_after_flush", {31'b0, irq}, 32'h0);
        cpu_read(32'h4, d); check("flush_status", d, 32'h001);

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            r = $urandom_range(0, 7);
            send_frame(8'($urandom_range(0, 255)), r == 0, r == 1, 0);
            check_status("rand_status");
            check("rand_code", {24'b0, code}, {24'b0, m_code});
            check_irq("rand_irq");
            for (int k = $urandom_range(0, 3); k > 0; k--) read_data_model("rand_data");
            if ($urandom_range(0, 3) == 0) ctrl_write(3'($urandom_range(0, 7)));
            check_status("rand_status2");
            check_irq("rand_irq2");
        end

        // Reset mid-frame
        send_bits(11'b0000_1100_110, 6, 0);
        do_reset();
        check_status("midframe_reset_status");
        check("midframe_reset_code", {24'b0, code}, 32'h0);
        check("midframe_reset_irq", {31'b0, irq}, 32'h0);
        b = 8'($urandom_range(0, 255));
        send_frame(b, 1'b0, 1'b0, 0);
        check_status("after_reset_status");
        read_data_model("after_reset_data");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
